// File: rtl/mesi_bus_pkg.sv
// mesi_bus_pkg: shared command/state encodings for the MESI snooping-bus controller
package mesi_bus_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE     = 2'd0,
    CMD_BUS_RD   = 2'd1,
    CMD_BUS_RDX  = 2'd2,
    CMD_BUS_UPGR = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SNOOP   = 3'd1,
    S_WB      = 3'd2,
    S_MEM_RD  = 3'd3,
    S_DONE    = 3'd4,
    S_RELEASE = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/mesi_bus_ctrl_snoop.sv
// mesi_snoop_collect: gathers per-peer snoop responses into a sticky mask plus shared/dirty/data summary
module mesi_snoop_collect #(
  parameter int N  = 2,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_en,
  input  logic [N-1:0]    i_src,
  input  logic [N-1:0]    i_ack,
  input  logic [N-1:0]    i_shared,
  input  logic [N-1:0]    i_dirty,
  input  logic [N*DW-1:0] i_data,
  output logic            o_all_acked,
  output logic            o_any_shared,
  output logic            o_any_dirty,
  output logic [DW-1:0]   o_dirty_data
);

  logic [N-1:0]  r_mask, r_shared, r_dirty;
  logic [DW-1:0] r_data [N];
  logic [N-1:0]  w_take, w_mask, w_shared, w_dirty;
  logic [DW-1:0] w_data [N];

  // The requester's own ack never counts; acks are only honoured while snooping.
  assign w_take   = i_en ? (i_ack & ~i_src) : '0;
  assign w_mask   = r_mask | w_take;
  assign w_shared = (r_shared & ~w_take) | (w_take & i_shared);
  assign w_dirty  = (r_dirty & ~w_take) | (w_take & i_dirty);

  // Summaries include the current cycle's acks so the FSM can leave SNOOP right after the last ack.
  assign o_all_acked  = &(w_mask | i_src);
  assign o_any_shared = |(w_shared | w_dirty);
  assign o_any_dirty  = |w_dirty;

  // Forward data acked this cycle, otherwise the captured copy.
  always_comb begin
    for (int i = 0; i < N; i++)
      w_data[i] = w_take[i] ? i_data[i*DW +: DW] : r_data[i];
  end

  // Lowest-index dirty peer wins: scan high to low so the lowest overrides.
  always_comb begin
    o_dirty_data = '0;
    for (int i = N - 1; i >= 0; i--)
      if (w_dirty[i]) o_dirty_data = w_data[i];
  end

  // Sticky capture of responses; cleared when a new transaction starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask   <= '0;
      r_shared <= '0;
      r_dirty  <= '0;
      for (int i = 0; i < N; i++) r_data[i] <= '0;
    end else if (i_start) begin
      r_mask   <= '0;
      r_shared <= '0;
      r_dirty  <= '0;
    end else begin
      r_mask   <= w_mask;
      r_shared <= w_shared;
      r_dirty  <= w_dirty;
      for (int i = 0; i < N; i++)
        if (w_take[i]) r_data[i] <= i_data[i*DW +: DW];
    end
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// mesi_bus_ctrl: snooping-bus transaction controller between the arbiter, peer caches and memory
module mesi_bus_ctrl
  import mesi_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       i_grant,
  input  logic [N*CMD_W-1:0] i_cache_cmd,
  input  logic [N*AW-1:0]    i_cache_addr,
  output logic               o_snp_valid,
  output logic [CMD_W-1:0]   o_snp_cmd,
  output logic [AW-1:0]      o_snp_addr,
  output logic [N-1:0]       o_snp_src,
  input  logic [N-1:0]       i_snp_ack,
  input  logic [N-1:0]       i_snp_shared,
  input  logic [N-1:0]       i_snp_dirty,
  input  logic [N*DW-1:0]    i_snp_data,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  input  logic               i_mem_ack,
  input  logic [DW-1:0]      i_mem_rdata,
  output logic [N-1:0]       o_done,
  output logic [DW-1:0]      o_rsp_data,
  output logic               o_rsp_shared
);

  ctrl_state_t      r_state;
  bus_cmd_t         r_cmd;
  logic [N-1:0]     r_src;
  logic [AW-1:0]    r_addr;
  logic [CMD_W-1:0] w_req_cmd, w_src_cmd;
  logic [AW-1:0]    w_req_addr;
  logic             w_onehot, w_accept, w_release, w_rsp_shared;
  logic             w_all_acked, w_any_shared, w_any_dirty;
  logic [DW-1:0]    w_dirty_data;

  // Select the granted cache's command/address and the latched requester's live command.
  always_comb begin
    w_req_cmd  = '0;
    w_req_addr = '0;
    w_src_cmd  = '0;
    for (int i = 0; i < N; i++) begin
      if (i_grant[i]) begin
        w_req_cmd  = w_req_cmd | i_cache_cmd[i*CMD_W +: CMD_W];
        w_req_addr = w_req_addr | i_cache_addr[i*AW +: AW];
      end
      if (r_src[i]) w_src_cmd = w_src_cmd | i_cache_cmd[i*CMD_W +: CMD_W];
    end
  end

  assign w_onehot     = (i_grant != '0) && ((i_grant & (i_grant - 1'b1)) == '0);
  assign w_accept     = (r_state == S_IDLE) && w_onehot && (w_req_cmd != CMD_NONE);
  assign w_release    = ((i_grant & r_src) == '0) || (w_src_cmd == CMD_NONE);
  assign w_rsp_shared = (r_cmd == CMD_BUS_RD) && w_any_shared;

  mesi_snoop_collect #(.N(N), .DW(DW)) u_collect (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_accept),
    .i_en         (r_state == S_SNOOP),
    .i_src        (r_src),
    .i_ack        (i_snp_ack),
    .i_shared     (i_snp_shared),
    .i_dirty      (i_snp_dirty),
    .i_data       (i_snp_data),
    .o_all_acked  (w_all_acked),
    .o_any_shared (w_any_shared),
    .o_any_dirty  (w_any_dirty),
    .o_dirty_data (w_dirty_data)
  );

  // Transaction FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd        <= CMD_NONE;
      r_src        <= '0;
      r_addr       <= '0;
      o_snp_valid  <= 1'b0;
      o_snp_cmd    <= '0;
      o_snp_addr   <= '0;
      o_snp_src    <= '0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_done       <= '0;
      o_rsp_data   <= '0;
      o_rsp_shared <= 1'b0;
    end else begin
      o_done <= '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_src       <= i_grant;
          r_cmd       <= bus_cmd_t'(w_req_cmd);
          r_addr      <= w_req_addr;
          o_snp_valid <= 1'b1;
          o_snp_cmd   <= w_req_cmd;
          o_snp_addr  <= w_req_addr;
          o_snp_src   <= i_grant;
          r_state     <= S_SNOOP;
        end
        S_SNOOP: if (w_all_acked) begin
          o_snp_valid <= 1'b0;
          if (r_cmd == CMD_BUS_UPGR) begin
            o_done       <= r_src;
            o_rsp_shared <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= w_any_dirty;
            o_mem_addr  <= r_addr;
            o_mem_wdata <= w_dirty_data;
            r_state     <= w_any_dirty ? S_WB : S_MEM_RD;
          end
        end
        S_WB, S_MEM_RD: if (i_mem_ack) begin
          o_mem_req    <= 1'b0;
          o_mem_we     <= 1'b0;
          o_done       <= r_src;
          o_rsp_data   <= (r_state == S_WB) ? o_mem_wdata : i_mem_rdata;
          o_rsp_shared <= w_rsp_shared;
          r_state      <= S_DONE;
        end
        S_DONE: r_state <= S_RELEASE;
        S_RELEASE: if (w_release) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// tb_mesi_bus_ctrl: directed checks of the bus controller with N=2 and N=4 instances
module tb_mesi_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   g2 = '0, ack2 = '0, sh2 = '0, dt2 = '0;
  logic [3:0]   c2 = '0;
  logic [63:0]  a2 = '0, sd2 = '0;
  logic         mack2 = 1'b0;
  logic [31:0]  mrd2 = '0;
  logic         sv2, mreq2, mwe2, rsh2;
  logic [1:0]   scmd2, ssrc2, done2;
  logic [31:0]  saddr2, maddr2, mwd2, rdat2;

  logic [3:0]   g4 = '0, ack4 = '0, sh4 = '0, dt4 = '0;
  logic [7:0]   c4 = '0;
  logic [127:0] a4 = '0, sd4 = '0;
  logic         mack4 = 1'b0;
  logic [31:0]  mrd4 = '0;
  logic         sv4, mreq4, mwe4, rsh4;
  logic [1:0]   scmd4;
  logic [3:0]   ssrc4, done4;
  logic [31:0]  saddr4, maddr4, mwd4, rdat4;

  mesi_bus_ctrl #(.N(2), .AW(32), .DW(32)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i_grant(g2), .i_cache_cmd(c2), .i_cache_addr(a2),
    .o_snp_valid(sv2), .o_snp_cmd(scmd2), .o_snp_addr(saddr2), .o_snp_src(ssrc2),
    .i_snp_ack(ack2), .i_snp_shared(sh2), .i_snp_dirty(dt2), .i_snp_data(sd2),
    .o_mem_req(mreq2), .o_mem_we(mwe2), .o_mem_addr(maddr2), .o_mem_wdata(mwd2),
    .i_mem_ack(mack2), .i_mem_rdata(mrd2), .o_done(done2), .o_rsp_data(rdat2),
    .o_rsp_shared(rsh2)
  );

  mesi_bus_ctrl #(.N(4), .AW(32), .DW(32)) u_d4 (
    .clk(clk), .rst_n(rst_n), .i_grant(g4), .i_cache_cmd(c4), .i_cache_addr(a4),
    .o_snp_valid(sv4), .o_snp_cmd(scmd4), .o_snp_addr(saddr4), .o_snp_src(ssrc4),
    .i_snp_ack(ack4), .i_snp_shared(sh4), .i_snp_dirty(dt4), .i_snp_data(sd4),
    .o_mem_req(mreq4), .o_mem_we(mwe4), .o_mem_addr(maddr4), .o_mem_wdata(mwd4),
    .i_mem_ack(mack4), .i_mem_rdata(mrd4), .o_done(done4), .o_rsp_data(rdat4),
    .o_rsp_shared(rsh4)
  );

  int n_pass = 0, n_chk = 0;
  int rd_cnt = 0, wr_cnt = 0, req_cyc = 0;
  int rd_s, wr_s, req_s;

  // Count memory handshakes and request cycles of the N=2 instance.
  always @(posedge clk) begin
    if (mreq2 && mack2) begin
      if (mwe2) wr_cnt <= wr_cnt + 1;
      else rd_cnt <= rd_cnt + 1;
    end
    if (mreq2) req_cyc <= req_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    chk("rst_snp_valid", {31'd0, sv2}, 32'd0);
    chk("rst_mem_req", {31'd0, mreq2}, 32'd0);
    chk("rst_done", {30'd0, done2}, 32'd0);
    chk("rst_rsp_data", rdat2, 32'd0);
    rst_n = 1'b1;

    // Clean BUS_RD from cache0 served by memory.
    g2 = 2'b01; c2 = 4'b0001; a2 = {32'h0, 32'h100};
    tick();
    chk("rd_snp_valid", {31'd0, sv2}, 32'd1);
    chk("rd_snp_cmd", {30'd0, scmd2}, 32'd1);
    chk("rd_snp_addr", saddr2, 32'h100);
    chk("rd_snp_src", {30'd0, ssrc2}, 32'd1);
    tick();
    chk("rd_snp_wait", {31'd0, sv2}, 32'd1);
    ack2 = 2'b10; sh2 = 2'b00;
    tick();
    ack2 = '0;
    chk("rd_snp_drop", {31'd0, sv2}, 32'd0);
    chk("rd_mem_req", {31'd0, mreq2}, 32'd1);
    chk("rd_mem_we", {31'd0, mwe2}, 32'd0);
    chk("rd_mem_addr", maddr2, 32'h100);
    tick(2);
    chk("rd_no_done_early", {30'd0, done2}, 32'd0);
    mack2 = 1'b1; mrd2 = 32'hAAAA;
    tick();
    mack2 = 1'b0;
    chk("rd_done", {30'd0, done2}, 32'd1);
    chk("rd_rsp_data", rdat2, 32'hAAAA);
    chk("rd_rsp_shared", {31'd0, rsh2}, 32'd0);
    chk("rd_mem_req_fall", {31'd0, mreq2}, 32'd0);
    tick();
    chk("rd_done_pulse", {30'd0, done2}, 32'd0);
    chk("rd_one_read", rd_cnt, 32'd1);
    chk("rd_no_write", wr_cnt, 32'd0);

    // Held request must not be re-accepted.
    tick(3);
    chk("hold_no_snoop", {31'd0, sv2}, 32'd0);
    c2 = 4'b0000;
    tick();
    chk("hold_idle", {31'd0, sv2}, 32'd0);

    // Reasserted BUS_RD hits a dirty peer: write-back, no memory read.
    c2 = 4'b0001;
    tick();
    chk("dirty_restart", {31'd0, sv2}, 32'd1);
    ack2 = 2'b10; dt2 = 2'b10; sd2 = {32'h5555, 32'h0};
    tick();
    ack2 = '0; dt2 = '0; sd2 = {32'hDEAD, 32'h0};
    chk("wb_mem_req", {31'd0, mreq2}, 32'd1);
    chk("wb_mem_we", {31'd0, mwe2}, 32'd1);
    chk("wb_mem_addr", maddr2, 32'h100);
    chk("wb_mem_wdata", mwd2, 32'h5555);
    tick();
    mack2 = 1'b1; mrd2 = 32'hBEEF;
    tick();
    mack2 = 1'b0;
    chk("wb_done", {30'd0, done2}, 32'd1);
    chk("wb_rsp_data", rdat2, 32'h5555);
    chk("wb_rsp_shared", {31'd0, rsh2}, 32'd1);
    chk("wb_one_write", wr_cnt, 32'd1);
    chk("wb_no_read", rd_cnt, 32'd1);
    g2 = '0; c2 = '0;
    tick(2);

    // Fastest UPGR from cache1: done two cycles after accept, no memory traffic.
    req_s = req_cyc;
    g2 = 2'b10; c2 = 4'b1100; a2 = {32'h200, 32'h0};
    tick();
    chk("upg_snp_src", {30'd0, ssrc2}, 32'd2);
    chk("upg_snp_cmd", {30'd0, scmd2}, 32'd3);
    chk("upg_snp_addr", saddr2, 32'h200);
    ack2 = 2'b01; sh2 = 2'b01;
    tick();
    ack2 = '0; sh2 = '0;
    chk("upg_done", {30'd0, done2}, 32'd2);
    chk("upg_rsp_shared", {31'd0, rsh2}, 32'd0);
    chk("upg_snp_drop", {31'd0, sv2}, 32'd0);
    tick();
    chk("upg_no_mem", req_cyc - req_s, 32'd0);
    g2 = '0; c2 = '0;
    tick(2);

    // N=4 RDX: staggered acks, requester's own ack ignored, shared ignored for RDX.
    g4 = 4'b0001; c4 = 8'b0000_0010; a4 = {96'h0, 32'h300};
    tick();
    chk("n4_snp_valid", {31'd0, sv4}, 32'd1);
    ack4 = 4'b1001; dt4 = 4'b0001;
    tick();
    ack4 = '0; dt4 = '0;
    chk("n4_after_ack3", {31'd0, sv4}, 32'd1);
    ack4 = 4'b0010; sh4 = 4'b0010;
    tick();
    ack4 = '0; sh4 = '0;
    chk("n4_after_ack1", {31'd0, sv4}, 32'd1);
    chk("n4_no_mem_yet", {31'd0, mreq4}, 32'd0);
    ack4 = 4'b0100;
    tick();
    ack4 = '0;
    chk("n4_snp_drop", {31'd0, sv4}, 32'd0);
    chk("n4_mem_req", {31'd0, mreq4}, 32'd1);
    chk("n4_mem_we", {31'd0, mwe4}, 32'd0);
    mack4 = 1'b1; mrd4 = 32'h1234;
    tick();
    mack4 = 1'b0;
    chk("n4_done", {28'd0, done4}, 32'd1);
    chk("n4_rsp_data", rdat4, 32'h1234);
    chk("n4_rsp_shared", {31'd0, rsh4}, 32'd0);
    g4 = '0; c4 = '0;
    tick(2);

    // Asynchronous reset in the middle of a memory read.
    g2 = 2'b01; c2 = 4'b0001; a2 = {32'h0, 32'h140};
    tick();
    ack2 = 2'b10;
    tick();
    ack2 = '0;
    chk("ar_mem_req_pre", {31'd0, mreq2}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mem_req", {31'd0, mreq2}, 32'd0);
    chk("ar_snp_valid", {31'd0, sv2}, 32'd0);
    chk("ar_done", {30'd0, done2}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_reaccept", {31'd0, sv2}, 32'd1);
    chk("ar_reaccept_addr", saddr2, 32'h140);
    ack2 = 2'b10;
    tick();
    ack2 = '0;
    mack2 = 1'b1; mrd2 = 32'h7777;
    tick();
    mack2 = 1'b0;
    chk("ar_done_after", {30'd0, done2}, 32'd1);
    chk("ar_rsp_data", rdat2, 32'h7777);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mesi_bus_ctrl.md
# mesi_bus_ctrl

Snooping-bus transaction controller for the N-cache MESI subsystem, sitting directly downstream of the round-robin bus arbiter. It takes the arbiter's one-hot grant and the granted cache's bus command, then:
- broadcasts the command to all other caches and collects their snoop responses;
- fetches data from memory, or takes it from a dirty peer and writes that line back;
- returns a completion pulse, data and a shared flag to the requester.

## Interface
- N, 2, number of caches (must match arbiter)
- AW, 32, address width
- DW, 32, line/data width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low: one clock; reset is asynchronous and active-low
- grant  in  N  one-hot grant from arbiter
- cache_cmd  in  2N  per-cache command, 2 bits each: 0 NONE, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR
- cache_addr  in  N*AW  per-cache request address
- snp_valid  out  1  snoop broadcast active
- snp_cmd  out  2  broadcast command
- snp_addr  out  AW  broadcast address
- snp_src  out  N  one-hot requester, so snoopers ignore their own request
- snp_ack  in  N  per-cache snoop-done pulse
- snp_shared  in  N  peer holds line (valid with ack)
- snp_dirty  in  N  peer holds line M (valid with ack)
- snp_data  in  N*DW  peer line data (valid with ack)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write-back, 0 = read
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  write-back data
- mem_ack  in  1  memory done pulse; mem_rdata valid same cycle
- mem_rdata  in  DW  memory read data
- done  out  N  one-hot completion pulse to requester
- rsp_data  out  DW  line data, valid with done
- rsp_shared  out  1  requester installs S (1) or E/M (0), valid with done

## Operation
- FSM states: IDLE, SNOOP, WB, MEM_RD, DONE, RELEASE.
- IDLE:
  - Accept when grant has exactly one bit set and that cache's cmd ≠ NONE.
  - Latch src, cmd and addr, clear the ack mask, go to SNOOP.
  - Zero or multiple grant bits: no accept, stay in IDLE.
- SNOOP:
  - snp_valid=1, with snp_cmd, snp_addr and snp_src driven from the latched values.
  - Each snp_ack[i] (i≠src) sets sticky mask bit i and captures shared/dirty/data for cache i; snp_ack[src] is ignored.
  - When the mask covers all i≠src (N=1: immediately), leave SNOOP:
    - cmd==UPGR → DONE;
    - any dirty → WB, with data from the lowest-index dirty cache;
    - else → MEM_RD.
- WB: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=dirty data. On mem_ack → DONE, rsp_data=dirty data.
- MEM_RD: mem_req=1, mem_we=0. On mem_ack → DONE, rsp_data=mem_rdata.
- DONE: done[src]=1 for one cycle. rsp_shared = (cmd==BUS_RD) && |(captured shared|dirty). Then go to RELEASE.
- RELEASE: wait until grant[src]==0 or cache_cmd[src]==NONE, then go to IDLE. This prevents the same request from being re-accepted.
- Reset (any time, including mid-transaction): all outputs 0, state IDLE, ack mask cleared, mem_req dropped immediately (asynchronously).

## Timing
- All outputs are registered. Reset value of every output is 0.
- Accept at cycle t (IDLE sees the request) → snp_valid high from t+1.
- Fastest UPGR: all acks at t+1 → done at t+2.
- Acks may arrive on different cycles. Leaving SNOOP happens in the cycle after the last ack; snp_valid drops in that same cycle.
- MEM_RD/WB: mem_req rises on state entry and falls the cycle after mem_ack; done is asserted the cycle after mem_ack.
- mem_ack outside WB/MEM_RD and snp_ack outside SNOOP are ignored.
- Snoop data is captured only on the ack cycle; later changes to snp_data are ignored.

## Structure
- Package mesi_bus_pkg:
  - bus_cmd_t enum (NONE, BUS_RD, BUS_RDX, BUS_UPGR);
  - ctrl_state_t enum;
  - CMD_W=2.
- Sub-module mesi_snoop_collect, which owns:
  - the sticky ack mask and source masking;
  - the all-acked flag;
  - OR of shared/dirty;
  - lowest-index dirty select with data capture.
- It is cleared by a start pulse from the FSM.

## Test plan
- N=2, grant=01, cmd0=BUS_RD, addr=0x100; cache1 acks at +2 with shared=0; mem_ack after 3 cycles with rdata=0xAAAA → exactly one mem read at 0x100, done=01, rsp_data=0xAAAA, rsp_shared=0.
- Same transaction, but cache1 acks with dirty=1, data=0x5555 → mem write at 0x100 with wdata=0x5555, no mem read, rsp_data=0x5555, rsp_shared=1.
- grant=10, cmd1=BUS_UPGR; cache0 acks at t+1 → done=10 at t+2, mem_req never asserted.
- N=4, cmd0=BUS_RDX; acks from caches 3,1,2 on separate cycles, snp_ack[0] pulsed → snp_valid held until cache 2's ack, then the read proceeds; rsp_shared=0 even though cache 1 reported shared.
- After done, hold grant=01 and cmd0=BUS_RD for 3 more cycles → no second snp_valid; the transaction restarts only after cmd0 goes NONE and is then reasserted.
- Deassert rst_n while in MEM_RD with mem_req=1 → mem_req, snp_valid and done go 0 asynchronously; after release the FSM is in IDLE and accepts a new grant normally.
